// File: rtl/instr_wait_ram_if.sv
// Simple request/grant bus between the instruction fetch master and its memory slave.
interface naive_bus;
   logic        rd_req;
   logic        rd_gnt;
   logic [3:0]  rd_be;
   logic [31:0] rd_addr;
   logic [31:0] rd_data;
   logic        wr_req;
   logic        wr_gnt;
   logic [3:0]  wr_be;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;

   modport master (
      output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
      input  rd_gnt, rd_data, wr_gnt
   );

   modport slave (
      input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
      output rd_gnt, rd_data, wr_gnt
   );
endinterface

// File: rtl/instr_wait_ram.sv
// Instruction-side word RAM with configurable read wait states (IDLE/WAIT FSM).
// Optional macro INSTR_RAM_WRITE_EN: defined -> bus writes update memory; undefined -> ROM.
module instr_wait_ram #(
   parameter int ADDR_LEN    = 12,
   parameter int WAIT_CYCLES = 0
) (
   input logic       clk,
   input logic       rstn,
   naive_bus.slave   bus
);

   localparam int DEPTH = 1 << ADDR_LEN;
   // The request cycle itself counts as the first wait cycle, so WAIT starts one short.
   localparam logic [3:0] RELOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

`ifdef INSTR_RAM_WRITE_EN
   localparam bit WRITE_EN = 1'b1;
`else
   localparam bit WRITE_EN = 1'b0;
`endif

   typedef enum logic {IDLE, WAIT} state_t;

   state_t              state, state_nxt;
   logic [3:0]          cnt, cnt_nxt;
   logic [ADDR_LEN-1:0] lat_idx, lat_idx_nxt;
   logic [ADDR_LEN-1:0] rd_idx, wr_idx;
   logic [31:0]         rd_data;
   logic                rd_gnt, wr_gnt;
   logic [31:0]         mem [0:DEPTH-1];
   logic                unused_bits;

   assign rd_idx = bus.rd_addr[ADDR_LEN+1:2];
   assign wr_idx = bus.wr_addr[ADDR_LEN+1:2];

   // Byte enables on reads and the aliased address bits carry no information here.
   assign unused_bits = ^{bus.rd_be, bus.rd_addr[1:0], bus.rd_addr[31:ADDR_LEN+2],
                          bus.wr_addr[1:0], bus.wr_addr[31:ADDR_LEN+2]};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         cnt     <= '0;
         lat_idx <= '0;
         rd_data <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         lat_idx <= lat_idx_nxt;
         if (rd_gnt)
            rd_data <= mem[rd_idx];
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      lat_idx_nxt = lat_idx;
      if (WAIT_CYCLES != 0) begin
         case (state)
            IDLE: begin
               if (bus.rd_req) begin
                  state_nxt   = WAIT;
                  cnt_nxt     = RELOAD;
                  lat_idx_nxt = rd_idx;
               end
            end
            WAIT: begin
               if (!bus.rd_req) begin
                  state_nxt = IDLE;
                  cnt_nxt   = '0;
               end else if (rd_idx != lat_idx) begin
                  // branch redirect: the stale fetch is dropped and timing restarts
                  cnt_nxt     = RELOAD;
                  lat_idx_nxt = rd_idx;
               end else if (bus.wr_req) begin
                  cnt_nxt = cnt;
               end else if (cnt == '0) begin
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt - 4'd1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      rd_gnt = 1'b0;
      wr_gnt = rstn & bus.wr_req;
      if (rstn && bus.rd_req && !bus.wr_req) begin
         if (WAIT_CYCLES == 0)
            rd_gnt = 1'b1;
         else if (state == WAIT && cnt == '0 && rd_idx == lat_idx)
            rd_gnt = 1'b1;
      end
   end

   // Memory has no reset so its contents survive rstn.
   always_ff @(posedge clk) begin
      if (WRITE_EN && wr_gnt) begin
         for (int b = 0; b < 4; b++)
            if (bus.wr_be[b])
               mem[wr_idx][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
      end
   end

   assign bus.rd_gnt  = rd_gnt;
   assign bus.wr_gnt  = wr_gnt;
   assign bus.rd_data = rd_data;

endmodule

// File: tb/tb_instr_wait_ram.sv
// Directed bench for instr_wait_ram with three instances (0, 2 and 3 wait cycles).
module tb_instr_wait_ram;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   errors = 0;
   int   checks = 0;

`ifdef INSTR_RAM_WRITE_EN
   localparam logic [31:0] EXP_WR = 32'h1122CCDD;
`else
   localparam logic [31:0] EXP_WR = 32'h11223344;
`endif

   naive_bus b0();
   naive_bus b2();
   naive_bus b3();

   instr_wait_ram #(.ADDR_LEN(12), .WAIT_CYCLES(0)) d0 (.clk(clk), .rstn(rstn), .bus(b0));
   instr_wait_ram #(.ADDR_LEN(12), .WAIT_CYCLES(2)) d2 (.clk(clk), .rstn(rstn), .bus(b2));
   instr_wait_ram #(.ADDR_LEN(12), .WAIT_CYCLES(3)) d3 (.clk(clk), .rstn(rstn), .bus(b3));

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_bus();
      b0.rd_req = 0; b0.rd_be = 4'hF; b0.rd_addr = 0; b0.wr_req = 0; b0.wr_be = 0; b0.wr_addr = 0; b0.wr_data = 0;
      b2.rd_req = 0; b2.rd_be = 4'hF; b2.rd_addr = 0; b2.wr_req = 0; b2.wr_be = 0; b2.wr_addr = 0; b2.wr_data = 0;
      b3.rd_req = 0; b3.rd_be = 4'hF; b3.rd_addr = 0; b3.wr_req = 0; b3.wr_be = 0; b3.wr_addr = 0; b3.wr_data = 0;
   endtask

   task automatic test_reset();
      tick();
      b0.rd_req = 1; b0.wr_req = 1; b2.rd_req = 1; b2.rd_addr = 32'h10;
      #1;
      checks++; if (b0.rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_rd_gnt: got %b want 0", b0.rd_gnt); end
      checks++; if (b0.wr_gnt !== 1'b0) begin errors++; $display("FAIL reset_wr_gnt: got %b want 0", b0.wr_gnt); end
      checks++; if (b2.rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", b2.rd_data); end
      idle_bus();
      tick();
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_w0_read();
      b0.rd_req = 1; b0.rd_addr = 32'h0C;
      #1;
      checks++; if (b0.rd_gnt !== 1'b1) begin errors++; $display("FAIL w0_gnt: got %b want 1", b0.rd_gnt); end
      tick();
      b0.rd_req = 0;
      #1;
      checks++; if (b0.rd_data !== 32'h00000013) begin errors++; $display("FAIL w0_data: got %h want 00000013", b0.rd_data); end
      // aliased high address bits, zero byte enables, different word
      tick();
      b0.rd_req = 1; b0.rd_be = 4'h0; b0.rd_addr = 32'h0000_4008;
      #1;
      checks++; if (b0.rd_gnt !== 1'b1) begin errors++; $display("FAIL w0_alias_gnt: got %b want 1", b0.rd_gnt); end
      tick();
      b0.rd_req = 0; b0.rd_be = 4'hF;
      #1;
      checks++; if (b0.rd_data !== 32'h11223344) begin errors++; $display("FAIL w0_alias_data: got %h want 11223344", b0.rd_data); end
      tick();
      #1;
      checks++; if (b0.rd_data !== 32'h11223344) begin errors++; $display("FAIL w0_hold: got %h want 11223344", b0.rd_data); end
   endtask

   task automatic test_wait2();
      logic [2:0] exp_gnt;
      exp_gnt = 3'b100;
      tick();
      b2.rd_req = 1; b2.rd_addr = 32'h10;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (b2.rd_gnt !== exp_gnt[c]) begin errors++; $display("FAIL w2_gnt_c%0d: got %b want %b", c, b2.rd_gnt, exp_gnt[c]); end
         tick();
      end
      b2.rd_req = 0;
      #1;
      checks++; if (b2.rd_data !== 32'h2222_0004) begin errors++; $display("FAIL w2_data: got %h want 22220004", b2.rd_data); end
   endtask

   task automatic test_abort();
      logic [2:0] exp_gnt;
      exp_gnt = 3'b100;
      tick();
      b2.rd_req = 1; b2.rd_addr = 32'h14;
      tick();
      b2.rd_req = 0;
      #1;
      checks++; if (b2.rd_gnt !== 1'b0) begin errors++; $display("FAIL abort_gnt: got %b want 0", b2.rd_gnt); end
      tick();
      b2.rd_req = 1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (b2.rd_gnt !== exp_gnt[c]) begin errors++; $display("FAIL abort_restart_c%0d: got %b want %b", c, b2.rd_gnt, exp_gnt[c]); end
         if (c == 1) begin
            checks++; if (b2.rd_data !== 32'h2222_0004) begin errors++; $display("FAIL abort_hold: got %h want 22220004", b2.rd_data); end
         end
         tick();
      end
      b2.rd_req = 0;
      #1;
      checks++; if (b2.rd_data !== 32'h2222_0005) begin errors++; $display("FAIL abort_data: got %h want 22220005", b2.rd_data); end
   endtask

   task automatic test_redirect();
      logic [4:0] exp_gnt;
      exp_gnt = 5'b10000;
      tick();
      b3.rd_req = 1; b3.rd_addr = 32'h10;
      for (int c = 0; c < 5; c++) begin
         if (c == 1) b3.rd_addr = 32'h40;
         #1;
         checks++; if (b3.rd_gnt !== exp_gnt[c]) begin errors++; $display("FAIL redir_gnt_c%0d: got %b want %b", c, b3.rd_gnt, exp_gnt[c]); end
         tick();
      end
      b3.rd_req = 0;
      #1;
      checks++; if (b3.rd_data !== 32'h3333_0040) begin errors++; $display("FAIL redir_data: got %h want 33330040", b3.rd_data); end
   endtask

   task automatic test_write_priority();
      tick();
      b0.wr_req = 1; b0.wr_addr = 32'h8; b0.wr_be = 4'b0011; b0.wr_data = 32'hAABBCCDD;
      b0.rd_req = 1; b0.rd_addr = 32'h8;
      #1;
      checks++; if (b0.wr_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %b want 1", b0.wr_gnt); end
      checks++; if (b0.rd_gnt !== 1'b0) begin errors++; $display("FAIL wr_prio_rd_gnt: got %b want 0", b0.rd_gnt); end
      tick();
      b0.wr_req = 0;
      #1;
      checks++; if (b0.rd_gnt !== 1'b1) begin errors++; $display("FAIL wr_after_gnt: got %b want 1", b0.rd_gnt); end
      tick();
      b0.rd_req = 0;
      #1;
      checks++; if (b0.rd_data !== EXP_WR) begin errors++; $display("FAIL wr_data: got %h want %h", b0.rd_data, EXP_WR); end
   endtask

   task automatic test_freeze();
      logic [3:0] exp_gnt;
      exp_gnt = 4'b1000;
      tick();
      b2.rd_req = 1; b2.rd_addr = 32'h18;
      for (int c = 0; c < 4; c++) begin
         b2.wr_req = (c == 1); b2.wr_addr = 32'h200; b2.wr_be = 4'h0;
         #1;
         checks++; if (b2.rd_gnt !== exp_gnt[c]) begin errors++; $display("FAIL freeze_gnt_c%0d: got %b want %b", c, b2.rd_gnt, exp_gnt[c]); end
         if (c == 1) begin
            checks++; if (b2.wr_gnt !== 1'b1) begin errors++; $display("FAIL freeze_wr_gnt: got %b want 1", b2.wr_gnt); end
         end
         tick();
      end
      b2.rd_req = 0; b2.wr_req = 0;
      #1;
      checks++; if (b2.rd_data !== 32'h2222_0006) begin errors++; $display("FAIL freeze_data: got %h want 22220006", b2.rd_data); end
   endtask

   task automatic test_reset_mid_wait();
      logic [2:0] exp_gnt;
      exp_gnt = 3'b100;
      tick();
      b2.rd_req = 1; b2.rd_addr = 32'h10;
      tick();
      #2;
      rstn = 1'b0;
      #1;
      checks++; if (b2.rd_gnt !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt: got %b want 0", b2.rd_gnt); end
      checks++; if (b2.rd_data !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", b2.rd_data); end
      tick();
      #1;
      checks++; if (b2.rd_gnt !== 1'b0) begin errors++; $display("FAIL rst_hold_gnt: got %b want 0", b2.rd_gnt); end
      tick();
      rstn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (b2.rd_gnt !== exp_gnt[c]) begin errors++; $display("FAIL rst_rel_gnt_c%0d: got %b want %b", c, b2.rd_gnt, exp_gnt[c]); end
         tick();
      end
      b2.rd_req = 0;
      #1;
      checks++; if (b2.rd_data !== 32'h2222_0004) begin errors++; $display("FAIL rst_rel_data: got %h want 22220004", b2.rd_data); end
   endtask

   initial begin
      idle_bus();
      d0.mem[3]  = 32'h0000_0013;
      d0.mem[2]  = 32'h1122_3344;
      d2.mem[4]  = 32'h2222_0004;
      d2.mem[5]  = 32'h2222_0005;
      d2.mem[6]  = 32'h2222_0006;
      d3.mem[4]  = 32'h3333_0004;
      d3.mem[16] = 32'h3333_0040;
      test_reset();
      test_w0_read();
      test_wait2();
      test_abort();
      test_redirect();
      test_write_priority();
      test_freeze();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
